change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
Downstream stage of the autoseller. Accepts one completed transaction (drink type plus change amount) and vends the drink. It then pays the change out serially, one coin per cycle. Coin selection is greedy: 10, then 5, then 1. The 10 and 5 coins come from finite stock counters; 1-coins are unlimited. A done pulse closes each transaction, and ready_o back-pressures the autoseller output.

Parameters:
STOCK_W, 4, width of each coin stock counter
INIT_TEN, 4, 10-coin stock after reset or refill (must be less than 2^STOCK_W)
INIT_FIVE, 4, 5-coin stock after reset or refill (must be less than 2^STOCK_W)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
enable_i  input  1  transaction valid; driven by autoseller enable_o
change_i  input  6  change amount 0..63; driven by autoseller change_o
drink_i  input  2  drink type; 00 = no drink (refund only); driven by autoseller drink_o
refill_i  input  1  reload both coin stocks to their INIT values
ready_o  output  1  high only in IDLE; a transaction is accepted when enable_i=1 and ready_o=1
drink_valid_o  output  1  one-cycle vend strobe
drink_o  output  2  latched drink type; meaningful only while drink_valid_o=1
coin_valid_o  output  1  one coin is dispensed this cycle
coin_o  output  2  coin code: 01 = 1, 10 = 5, 11 = 10; 00 when coin_valid_o=0
done_o  output  1  one-cycle end-of-transaction strobe
ten_cnt_o  output  STOCK_W  current 10-coin stock
five_cnt_o  output  STOCK_W  current 5-coin stock

Behaviour:
- Reset and clocking: one clock (clk). Reset is synchronous, active-high.
- Reset values: state IDLE, ready_o=1, all strobes 0, drink_o=00, coin_o=00, ten_cnt_o=INIT_TEN, five_cnt_o=INIT_FIVE, remaining=0.
- States: IDLE, VEND, PAY, DONE. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE:
  - On enable_i=1: latch change_i into remaining (6 bits) and latch drink_i.
  - Next state is VEND if drink_i is not 00, else PAY if change_i is not 0, else DONE.
  - enable_i is ignored in every state other than IDLE; data is not buffered.
- VEND: drink_valid_o=1 for exactly one cycle. Next state is PAY if remaining is not 0, else DONE.
- PAY, one coin per cycle:
  - If remaining >= 10 and ten stock > 0: coin 11, remaining -= 10, ten stock -= 1.
  - Else if remaining >= 5 and five stock > 0: coin 10, remaining -= 5, five stock -= 1.
  - Else: coin 01, remaining -= 1.
  - When the coin emitted this cycle brings remaining to 0, next state is DONE.
- DONE: done_o=1 for one cycle, ready_o=0. Next state is IDLE, so ready_o=1 the following cycle.
- Latency: for an accept edge at cycle N with a drink and change C coins:
  - drink_valid_o at N+1
  - coins at N+2 .. N+1+C
  - done_o at N+2+C
  - ready_o at N+3+C
  - Without a drink, each of these is one cycle earlier.
- Stock underflow cannot occur; a denomination with zero stock is skipped.
- refill_i:
  - Honoured only in IDLE; ignored elsewhere.
  - If refill_i and enable_i arrive in the same IDLE cycle, both take effect. The refill applies first, so the new transaction sees full stock.
- Reset mid-transaction: aborts immediately. The remaining change is discarded, stocks reload, and state returns to IDLE next cycle with no done_o.
- Width rule: all subtraction is on 6 bits. remaining never wraps because each coin value is at most the current remaining.

Decomposition:
- Package change_pkg:
  - state enum (IDLE, VEND, PAY, DONE)
  - coin codes COIN_NONE, COIN_1, COIN_5, COIN_10
  - DRINK_NONE = 2'b00
  - coin value constants 1, 5, 10
- Sub-module coin_stock: a parameterised stock counter with load (reset/refill), decrement, and nonzero flag outputs. Instantiated twice, once for the 10-coin stock and once for the 5-coin stock. Greedy selection stays in the top level.

Test Plan:
- Reset, then change 37, drink 01 -> drink_valid_o and drink_o=01 at N+1; coins 11,11,11,10,01,01; done_o at N+8; stocks end at ten=1, five=3.
- Change 0, drink 10 -> drink_valid_o at N+1, no coins, done_o at N+2, ready_o at N+3.
- Change 63, drink 00 -> no drink strobe; coins 11 x4, 10 x4, 01 x3 (11 coins); stocks end at 0/0. Then change 17 -> seventeen 01 coins.
- With stocks at 0, refill_i and enable_i together in IDLE with change 15 -> coins 11,10; stocks end at ten=3, five=3.
- enable_i pulses while in PAY -> ignored; coin sequence and count unchanged.
- reset asserted during PAY of change 30 -> coin_valid_o=0 the next cycle, no done_o, ready_o=1, stocks equal INIT values.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change dispenser: FSM states, coin codes
// and coin face values.
package change_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    VEND = 2'b01,
    PAY  = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_5    = 2'b10;
  localparam logic [1:0] COIN_10   = 2'b11;

  localparam logic [1:0] DRINK_NONE = 2'b00;

  localparam logic [5:0] VAL_1  = 6'd1;
  localparam logic [5:0] VAL_5  = 6'd5;
  localparam logic [5:0] VAL_10 = 6'd10;

endpackage

// File: rtl/change_dispenser_coin_stock.sv
// Finite coin stock counter: load to INIT, decrement on dispense, flag nonzero.
module coin_stock #(
  parameter int STOCK_W = 4,
  parameter int INIT    = 4
) (
  input  logic               clk,
  input  logic               load,
  input  logic               dec,
  output logic [STOCK_W-1:0] cnt,
  output logic               nonzero
);

  assign nonzero = (cnt != '0);

  // Load wins over decrement; an empty stock is never decremented.
  always_ff @(posedge clk) begin
    if (load) begin
      cnt <= STOCK_W'(INIT);
    end else if (dec && nonzero) begin
      cnt <= cnt - STOCK_W'(1);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Vends a drink, then pays change one coin per cycle with greedy 10/5/1
// selection from finite 10/5 stocks; done pulse closes each transaction.
module change_dispenser #(
  parameter int STOCK_W   = 4,
  parameter int INIT_TEN  = 4,
  parameter int INIT_FIVE = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_i,
  input  logic [5:0]         change_i,
  input  logic [1:0]         drink_i,
  input  logic               refill_i,
  output logic               ready_o,
  output logic               drink_valid_o,
  output logic [1:0]         drink_o,
  output logic               coin_valid_o,
  output logic [1:0]         coin_o,
  output logic               done_o,
  output logic [STOCK_W-1:0] ten_cnt_o,
  output logic [STOCK_W-1:0] five_cnt_o
);

  import change_pkg::*;

  state_t     state, state_nxt;
  logic [5:0] remaining, remaining_nxt;
  logic [1:0] drink_q, drink_nxt;
  logic       ten_nz, five_nz;
  logic       take_ten, take_five;
  logic [5:0] coin_val;
  logic [1:0] coin_code;
  logic       in_idle, in_pay;
  logic       stock_load;

  assign in_idle = (state == IDLE);
  assign in_pay  = (state == PAY);

  // Refill only lands while idle, so an accepted transaction sees full stock.
  assign stock_load = reset | (in_idle & refill_i);

  coin_stock #(.STOCK_W(STOCK_W), .INIT(INIT_TEN)) u_ten_stock (
    .clk     (clk),
    .load    (stock_load),
    .dec     (in_pay & take_ten),
    .cnt     (ten_cnt_o),
    .nonzero (ten_nz)
  );

  coin_stock #(.STOCK_W(STOCK_W), .INIT(INIT_FIVE)) u_five_stock (
    .clk     (clk),
    .load    (stock_load),
    .dec     (in_pay & take_five),
    .cnt     (five_cnt_o),
    .nonzero (five_nz)
  );

  always_comb begin
    take_ten  = (remaining >= VAL_10) && ten_nz;
    take_five = !take_ten && (remaining >= VAL_5) && five_nz;
    coin_val  = VAL_1;
    coin_code = COIN_1;
    if (take_ten) begin
      coin_val  = VAL_10;
      coin_code = COIN_10;
    end else if (take_five) begin
      coin_val  = VAL_5;
      coin_code = COIN_5;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    drink_nxt     = drink_q;
    unique case (state)
      IDLE: begin
        if (enable_i) begin
          remaining_nxt = change_i;
          drink_nxt     = drink_i;
          if (drink_i != DRINK_NONE) state_nxt = VEND;
          else if (change_i != '0)   state_nxt = PAY;
          else                       state_nxt = DONE;
        end
      end
      VEND: state_nxt = (remaining != '0) ? PAY : DONE;
      PAY: begin
        // coin_val never exceeds remaining, so this cannot wrap.
        remaining_nxt = remaining - coin_val;
        if (remaining_nxt == '0) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      drink_q   <= DRINK_NONE;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      drink_q   <= drink_nxt;
    end
  end

  assign ready_o       = in_idle;
  assign drink_valid_o = (state == VEND);
  assign drink_o       = drink_q;
  assign coin_valid_o  = in_pay;
  assign coin_o        = in_pay ? coin_code : COIN_NONE;
  assign done_o        = (state == DONE);

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: per-cycle comparison against a
// transaction-level model, plus directed literal scenarios and random traffic.
module tb_change_dispenser;

  localparam int SW    = 4;
  localparam int ITEN  = 4;
  localparam int IFIVE = 4;

  logic          clk;
  logic          reset;
  logic          enable_i;
  logic [5:0]    change_i;
  logic [1:0]    drink_i;
  logic          refill_i;
  logic          ready_o;
  logic          drink_valid_o;
  logic [1:0]    drink_o;
  logic          coin_valid_o;
  logic [1:0]    coin_o;
  logic          done_o;
  logic [SW-1:0] ten_cnt_o;
  logic [SW-1:0] five_cnt_o;

  change_dispenser #(.STOCK_W(SW), .INIT_TEN(ITEN), .INIT_FIVE(IFIVE)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable_i      (enable_i),
    .change_i      (change_i),
    .drink_i       (drink_i),
    .refill_i      (refill_i),
    .ready_o       (ready_o),
    .drink_valid_o (drink_valid_o),
    .drink_o       (drink_o),
    .coin_valid_o  (coin_valid_o),
    .coin_o        (coin_o),
    .done_o        (done_o),
    .ten_cnt_o     (ten_cnt_o),
    .five_cnt_o    (five_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs for one cycle.
  typedef struct packed {
    logic          rdy;
    logic          dv;
    logic [1:0]    drk;
    logic          cv;
    logic [1:0]    coin;
    logic          dn;
    logic [SW-1:0] ten;
    logic [SW-1:0] five;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   m_ten  = ITEN;
  int   m_five = IFIVE;

  function automatic exp_t idle_rec();
    exp_t e;
    e = '0;
    e.rdy  = 1'b1;
    e.ten  = SW'(m_ten);
    e.five = SW'(m_five);
    return e;
  endfunction

  // Expand one accepted transaction into its whole cycle-by-cycle output list.
  task automatic build(input int c, input logic [1:0] d);
    exp_t e;
    int   r;
    r = c;
    if (d != 2'b00) begin
      e = '0; e.dv = 1'b1; e.drk = d; e.ten = SW'(m_ten); e.five = SW'(m_five);
      q.push_back(e);
    end
    while (r > 0) begin
      e = '0; e.cv = 1'b1; e.ten = SW'(m_ten); e.five = SW'(m_five);
      if (r >= 10 && m_ten > 0)     begin e.coin = 2'b11; r -= 10; m_ten--;  end
      else if (r >= 5 && m_five > 0) begin e.coin = 2'b10; r -= 5;  m_five--; end
      else                           begin e.coin = 2'b01; r -= 1;            end
      q.push_back(e);
    end
    e = '0; e.dn = 1'b1; e.ten = SW'(m_ten); e.five = SW'(m_five);
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_ten = ITEN; m_five = IFIVE;
      q.delete();
      cur = idle_rec();
    end else if (q.size() != 0) begin
      cur = q.pop_front();
    end else if (cur.rdy) begin
      if (refill_i) begin m_ten = ITEN; m_five = IFIVE; end
      if (enable_i) begin
        build(int'(change_i), drink_i);
        cur = q.pop_front();
      end else begin
        cur = idle_rec();
      end
    end else begin
      cur = idle_rec();
    end
  end

  int   checks   = 0;
  int   failures = 0;
  bit   checking = 0;

  task automatic step();
    @(negedge clk);
    if (checking) begin
      checks++;
      if (ready_o !== cur.rdy || drink_valid_o !== cur.dv ||
          (cur.dv && drink_o !== cur.drk) || coin_valid_o !== cur.cv ||
          coin_o !== cur.coin || done_o !== cur.dn ||
          ten_cnt_o !== cur.ten || five_cnt_o !== cur.five) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t got rdy=%b dv=%b drk=%b cv=%b coin=%b dn=%b ten=%0d five=%0d want rdy=%b dv=%b drk=%b cv=%b coin=%b dn=%b ten=%0d five=%0d",
                 $time, ready_o, drink_valid_o, drink_o, coin_valid_o, coin_o, done_o,
                 ten_cnt_o, five_cnt_o, cur.rdy, cur.dv, cur.drk, cur.cv, cur.coin,
                 cur.dn, cur.ten, cur.five);
      end
    end
  endtask

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  int           lat, ncoins, dv_lat, done_lat;
  logic [1:0]   dv_drink;
  logic [127:0] coins_seen;
  bit           aborted;

  // Issue one transaction from an idle cycle; returns on the next idle cycle.
  task automatic txn(input logic [5:0] c, input logic [1:0] d, input logic rf,
                     input bit noisy, input int abort_at);
    int guard;
    guard = 0;
    enable_i = 1'b1; change_i = c; drink_i = d; refill_i = rf;
    step();
    enable_i = 1'b0; refill_i = 1'b0;
    lat = 1; ncoins = 0; coins_seen = '0; dv_lat = 0; dv_drink = 2'b00;
    done_lat = 0; aborted = 0;
    while (!done_o && guard < 80) begin
      if (drink_valid_o) begin dv_lat = lat; dv_drink = drink_o; end
      if (coin_valid_o) begin
        coins_seen[ncoins*2 +: 2] = coin_o;
        ncoins++;
      end
      enable_i = noisy ? 1'($urandom) : 1'b0;
      refill_i = noisy ? 1'($urandom) : 1'b0;
      change_i = 6'($urandom);
      drink_i  = 2'($urandom);
      if (abort_at != 0 && lat == abort_at) begin
        enable_i = 1'b0; refill_i = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        aborted = 1;
        return;
      end
      step();
      lat++; guard++;
    end
    enable_i = 1'b0; refill_i = 1'b0;
    done_lat = lat;
    lit("done_timeout", 64'(done_o), 64'd1);
    step();
  endtask

  task automatic do_reset();
    enable_i = 1'b0; refill_i = 1'b0; reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    logic [63:0] ones17;
    ones17 = {30'b0, {17{2'b01}}};
    reset = 1'b1; enable_i = 1'b0; change_i = '0; drink_i = '0; refill_i = 1'b0;
    step(); step();
    checking = 1;
    reset = 1'b0;
    step();
    lit("reset_ready", 64'(ready_o), 64'd1);
    lit("reset_drink", 64'(drink_o), 64'd0);
    lit("reset_coin",  64'(coin_o),  64'd0);
    lit("reset_ten",   64'(ten_cnt_o),  64'd4);
    lit("reset_five",  64'(five_cnt_o), 64'd4);

    // 37 with drink 01
    txn(6'd37, 2'b01, 1'b0, 1'b0, 0);
    lit("t37_dv_lat", 64'(dv_lat), 64'd1);
    lit("t37_drink",  64'(dv_drink), 64'd1);
    lit("t37_coins",  coins_seen[63:0], 64'h5BF);
    lit("t37_ncoins", 64'(ncoins), 64'd6);
    lit("t37_done",   64'(done_lat), 64'd8);
    lit("t37_ten",    64'(ten_cnt_o), 64'd1);
    lit("t37_five",   64'(five_cnt_o), 64'd3);

    // zero change with drink 10
    txn(6'd0, 2'b10, 1'b0, 1'b0, 0);
    lit("t0_dv_lat", 64'(dv_lat), 64'd1);
    lit("t0_ncoins", 64'(ncoins), 64'd0);
    lit("t0_done",   64'(done_lat), 64'd2);
    lit("t0_ready",  64'(ready_o), 64'd1);

    // 63 refund only from full stock, then 17 from empty stock
    do_reset();
    txn(6'd63, 2'b00, 1'b0, 1'b0, 0);
    lit("t63_dv",     64'(dv_lat), 64'd0);
    lit("t63_coins",  coins_seen[63:0], 64'h15AAFF);
    lit("t63_ncoins", 64'(ncoins), 64'd11);
    lit("t63_done",   64'(done_lat), 64'd12);
    lit("t63_ten",    64'(ten_cnt_o), 64'd0);
    lit("t63_five",   64'(five_cnt_o), 64'd0);
    txn(6'd17, 2'b00, 1'b0, 1'b0, 0);
    lit("t17_coins",  coins_seen[63:0], ones17);
    lit("t17_ncoins", 64'(ncoins), 64'd17);

    // refill together with enable
    txn(6'd15, 2'b00, 1'b1, 1'b0, 0);
    lit("t15_coins", coins_seen[63:0], 64'hB);
    lit("t15_ten",   64'(ten_cnt_o), 64'd3);
    lit("t15_five",  64'(five_cnt_o), 64'd3);

    // enable/refill noise while busy
    txn(6'd37, 2'b00, 1'b0, 1'b1, 0);
    lit("noise_coins",  coins_seen[63:0], 64'h5BF);
    lit("noise_ncoins", 64'(ncoins), 64'd6);

    // reset during PAY
    txn(6'd30, 2'b00, 1'b0, 1'b0, 3);
    lit("abort_taken", 64'(aborted), 64'd1);
    lit("abort_cv",    64'(coin_valid_o), 64'd0);
    lit("abort_done",  64'(done_o), 64'd0);
    lit("abort_ready", 64'(ready_o), 64'd1);
    lit("abort_ten",   64'(ten_cnt_o), 64'd4);
    lit("abort_five",  64'(five_cnt_o), 64'd4);

    // random traffic
    for (int i = 0; i < 150; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        refill_i = ($urandom_range(0, 3) == 0);
        change_i = 6'($urandom);
        drink_i  = 2'($urandom);
        step();
      end
      txn(6'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0),
          1'($urandom), ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 8)) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
